// File: rtl/mult_rr_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Tag width follows the requester count; tags ride alongside the multiplier pipe.
package mult_rr_sched_pkg;

    localparam int N_D    = 8;
    localparam int M_D    = 4;
    localparam int LAT_D  = 4;
    localparam int NREQ_D = 4;

    function automatic int tag_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int TW = tag_width(NREQ_D);

    typedef struct packed {
        logic          vld;
        logic [TW-1:0] idx;
    } tag_t;

    function automatic logic [NREQ_D-1:0] onehot(input logic [TW-1:0] i);
        return NREQ_D'(1) << i;
    endfunction

endpackage

// File: rtl/mult_rr_sched_if.sv
// Requester, multiplier and response signals of the scheduler.
// slave is the scheduler's view; master is the surrounding environment.
interface mult_rr_sched_if #(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_en;
    logic [NREQ-1:0]   req_vld;
    logic [NREQ-1:0]   req_rdy;
    logic [NREQ*N-1:0] req_mult1;
    logic [NREQ*M-1:0] req_mult2;
    logic              mul_data_rdy;
    logic [N-1:0]      mul_mult1;
    logic [M-1:0]      mul_mult2;
    logic              mul_res_rdy;
    logic [N+M-1:0]    mul_res;
    logic [NREQ-1:0]   rsp_vld;
    logic [N+M-1:0]    rsp_res;
    logic              err;

    modport slave (
        input  req_en, req_vld, req_mult1, req_mult2,
        input  mul_res_rdy, mul_res,
        output req_rdy, mul_data_rdy, mul_mult1, mul_mult2,
        output rsp_vld, rsp_res, err
    );

    modport master (
        output req_en, req_vld, req_mult1, req_mult2,
        output mul_res_rdy, mul_res,
        input  req_rdy, mul_data_rdy, mul_mult1, mul_mult2,
        input  rsp_vld, rsp_res, err
    );

endinterface

// File: rtl/mult_rr_sched_rr_arb_core.sv
// Round-robin arbiter: search starts one past the last granted index.
// Pointer only moves on a grant, so masked cycles leave priority untouched.
module rr_arb_core
    import mult_rr_sched_pkg::*;
#(
    parameter int NREQ = NREQ_D
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] elig,
    output logic [NREQ-1:0] gnt,
    output logic [TW-1:0]   gnt_idx,
    output logic            any
);

    logic [TW-1:0] ptr_q;
    logic [TW-1:0] ptr_d;
    logic [TW-1:0] c;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        c       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            c = TW'((int'(ptr_q) + k) % NREQ);
            if (!any && elig[c]) begin
                any     = 1'b1;
                gnt_idx = c;
            end
        end
        gnt   = any ? onehot(gnt_idx) : '0;
        ptr_d = any ? gnt_idx : ptr_q;
    end

    // Reset value makes requester 0 the first candidate.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q <= TW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Shares one pipelined multiplier among NREQ requesters, round-robin.
// Each issue is tagged with its owner so the result is routed back.
module mult_rr_sched
    import mult_rr_sched_pkg::*;
#(
    parameter int N    = N_D,
    parameter int M    = M_D,
    parameter int LAT  = LAT_D,
    parameter int NREQ = NREQ_D
) (
    input logic            clk,
    input logic            rstn,
    mult_rr_sched_if.slave bus
);

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [TW-1:0]   win;
    logic            any;

    tag_t            tag_q [LAT];
    tag_t            tag_d;
    logic [NREQ-1:0] rsp_vld_q;
    logic [NREQ-1:0] rsp_vld_d;
    logic [N+M-1:0]  rsp_res_q;
    logic            err_q;
    logic            err_d;

    // Reset gates eligibility so nothing is granted while rstn is low.
    assign elig = bus.req_vld & bus.req_en & {NREQ{rstn}};

    rr_arb_core #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .elig    (elig),
        .gnt     (gnt),
        .gnt_idx (win),
        .any     (any)
    );

    assign bus.req_rdy      = gnt;
    assign bus.mul_data_rdy = any;
    assign bus.mul_mult1    = any ? bus.req_mult1[win*N +: N] : '0;
    assign bus.mul_mult2    = any ? bus.req_mult2[win*M +: M] : '0;

    always_comb begin
        tag_d     = '{vld: any, idx: win};
        rsp_vld_d = '0;
        if (tag_q[LAT-1].vld) begin
            rsp_vld_d = onehot(tag_q[LAT-1].idx);
        end
        err_d = err_q | (tag_q[LAT-1].vld != bus.mul_res_rdy);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
            rsp_vld_q <= '0;
            rsp_res_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rsp_vld_q <= rsp_vld_d;
            rsp_res_q <= bus.mul_res;
            err_q     <= err_d;
        end
    end

    assign bus.rsp_vld = rsp_vld_q;
    assign bus.rsp_res = rsp_res_q;
    assign bus.err     = err_q;

endmodule
